bias_ram_loader_dense_1: RTL



---
 rtl/bias_ram_loader_dense_1_pkg.sv | 27 ++
 rtl/bias_ram_loader_dense_1_if.sv | 16 +
 rtl/bias_ram_loader_dense_1_ram.sv | 41 ++++
 rtl/bias_ram_loader_dense_1.sv | 103 ++++++++++
 4 files changed

// File: rtl/bias_ram_loader_dense_1_pkg.sv
`default_nettype none
// ============================================================================
// bias_loader_pkg : shared types and constants for the dense-1 bias loader.
// Optional feature macro: BIAS_LOAD_CHECKSUM_EN.   Revision: 1.0
// ============================================================================
package bias_loader_pkg;

    localparam int BIAS_DEPTH_DENSE1 = 128;
    localparam int BIAS_W            = 8;

`ifdef BIAS_LOAD_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bias_ld_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd3
    } bias_ld_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/bias_ram_loader_dense_1_if.sv
`default_nettype none
// ============================================================================
// bias_ram_loader_dense_1_if : byte stream from the SoC load bridge.
// Revision: 1.0
// ============================================================================
interface bias_ram_loader_dense_1_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/bias_ram_loader_dense_1_ram.sv
`default_nettype none
// ============================================================================
// bias_ram_1r1w : DEPTH x DATA_W storage, synchronous write, async read
// returning 0 outside the table.   Revision: 1.0
// ============================================================================
module bias_ram_1r1w #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;
    logic              w_in_range;
    logic              r_in_range;

    assign widx       = waddr[IDX_W-1:0];
    assign ridx       = raddr[IDX_W-1:0];
    assign w_in_range = (waddr < ADDR_W'(DEPTH));
    assign r_in_range = (raddr < ADDR_W'(DEPTH));

    // Contents are deliberately not reset; the loader's done flag qualifies them.
    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = r_in_range ? mem[ridx] : '0;

endmodule
`default_nettype wire

// File: rtl/bias_ram_loader_dense_1.sv
`default_nettype none
// ============================================================================
// bias_ram_loader_dense_1 : streams 128 signed biases into a RAM served through
// a combinational addr->data port. Macro BIAS_LOAD_CHECKSUM_EN adds a trailing
// checksum byte and the err flag.   Revision: 1.0
// ============================================================================
module bias_ram_loader_dense_1
    import bias_loader_pkg::*;
#(
    parameter int DEPTH  = BIAS_DEPTH_DENSE1,
    parameter int DATA_W = BIAS_W,
    parameter int ADDR_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    bias_ram_loader_dense_1_if.slave   s,
    input  wire logic [ADDR_W-1:0]     addr,
    output logic      [DATA_W-1:0]     data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic      [ADDR_W-1:0]     wr_count
);
    bias_ld_state_t state;
    logic           accept;
    logic           last;
    logic           we;

`ifdef BIAS_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign busy = (state == ST_LOAD) || (state == ST_CHECK);
`else
    assign busy = (state == ST_LOAD);
    assign err  = 1'b0;
`endif

    assign done      = (state == ST_DONE);
    assign s.s_ready = busy;
    assign accept    = s.s_valid && busy;
    assign last      = (wr_count == ADDR_W'(DEPTH - 1));
    assign we        = accept && (state == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_count <= '0;
`ifdef BIAS_LOAD_CHECKSUM_EN
            sum      <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        wr_count <= '0;
`ifdef BIAS_LOAD_CHECKSUM_EN
                        sum      <= '0;
                        err      <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_count <= wr_count + 1'b1;
`ifdef BIAS_LOAD_CHECKSUM_EN
                        sum      <= sum + s.s_data;
                        if (last) state <= ST_CHECK;
`else
                        if (last) state <= ST_DONE;
`endif
                    end
                end
`ifdef BIAS_LOAD_CHECKSUM_EN
                // Checksum byte is compared only; it never reaches the RAM.
                ST_CHECK: begin
                    if (accept) begin
                        err   <= (s.s_data != sum);
                        state <= ST_DONE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    bias_ram_1r1w #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (wr_count),
        .wdata  (s.s_data),
        .raddr  (addr),
        .rdata  (data)
    );

endmodule
`default_nettype wire
